writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 57 +++++
 rtl/writeback_stage_if.sv | 18 +
 rtl/writeback_stage_load_align.sv | 39 +++
 rtl/writeback_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Uop package: memory-stage uop layout, exception codes and writeback FSM types.
package Uop;

  typedef enum logic [1:0] {
    EX_NONE      = 2'd0,
    EX_MEM_ALIGN = 2'd1,
    EX_MEM_MISS  = 2'd2
  } ex_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_op_sz_t;

  typedef struct packed {
    logic       en;
    logic       isSt;
    mem_op_sz_t sz;
    logic       signExtend;
  } mem_op_t;

  typedef struct packed {
    ex_t         ex;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [3:0]  flags;
    logic        flagsValid;
    mem_op_t     memOp;
    logic [1:0]  addrLo;
  } memory_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_WAIT = 2'd1,
    ST_TRAP      = 2'd2
  } wb_state_t;

  // Everything needed to finish a missed load once the refill arrives.
  typedef struct packed {
    logic [4:0] rd;
    mem_op_sz_t sz;
    logic       signExtend;
    logic [1:0] addrLo;
  } miss_ctx_t;

  localparam miss_ctx_t MISS_CTX_RESET = '{rd: 5'd0, sz: SZ_B, signExtend: 1'b0, addrLo: 2'd0};

  function automatic logic is_misaligned(input mem_op_sz_t sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_H:    is_misaligned = addr_lo[0];
      SZ_W:    is_misaligned = (addr_lo != 2'd0);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Handshake and bypass interfaces used between the memory and writeback stages.
interface pipeline_if;
  logic valid;
  logic stall;

  modport Upstream   (input valid, output stall);
  modport Downstream (output valid, input stall);
endinterface

interface bypass_if;
  logic        rValid;
  logic [4:0]  r;
  logic [31:0] rVal;
  logic        flagsValid;

  modport Subject  (output rValid, r, rVal, flagsValid);
  modport Observer (input rValid, r, rVal, flagsValid);
endinterface

// File: rtl/writeback_stage_load_align.sv
// load_align: selects and extends a byte/half/word from a 32-bit load word.
module load_align
  import Uop::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addrLo,
  input  mem_op_sz_t  sz,
  input  logic        signExtend,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension
  always_comb begin
    byte_s = data[{addrLo, 3'b000} +: 8];
    half_s = data[{addrLo[1], 4'b0000} +: 16];
    case (sz)
      SZ_B: begin
        if (signExtend) begin
          result = {{24{byte_s[7]}}, byte_s};
        end else begin
          result = {24'd0, byte_s};
        end
      end
      SZ_H: begin
        if (signExtend) begin
          result = {{16{half_s[15]}}, half_s};
        end else begin
          result = {16'd0, half_s};
        end
      end
      SZ_W:    result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires memory-stage uops, waits out load misses, reports exceptions.
// Optional miss timeout (EX_MEM_MISS after MISS_TIMEOUT cycles) enabled by WB_MISS_TIMEOUT_EN.
module writeback_stage
  import Uop::*;
#(
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_if.Upstream        u,
  input  memory_t             uopIn,
  input  logic [31:0]         cacheRespData,
  input  logic                cacheHit,
  input  logic                cacheRespValid,
  output logic                rfWe,
  output logic [4:0]          rfAddr,
  output logic [31:0]         rfData,
  bypass_if.Subject           bypass,
  output logic                exValid,
  output ex_t                 exCode,
  output logic [63:0]         instret
);

  if (MISS_TIMEOUT < 32'sd1 || MISS_TIMEOUT > 32'sd255) begin : g_bad_timeout
    $error("MISS_TIMEOUT must be within 1..255");
  end

  wb_state_t   state_q, state_d;
  miss_ctx_t   ctx_q, ctx_d;
  logic [63:0] instret_q, instret_d;

  logic        retire_s, accepted_s, stall_s, rf_we_s, ex_valid_s;
  logic [4:0]  rf_addr_s;
  logic [31:0] rf_data_s;
  ex_t         ex_code_s;
  logic        is_load_s, misaligned_s, timeout_s;
  logic [1:0]  align_addr_s;
  mem_op_sz_t  align_sz_s;
  logic        align_se_s;
  logic [31:0] load_word_s;
  logic        unused_flags_s;

  assign is_load_s      = uopIn.memOp.en & ~uopIn.memOp.isSt;
  assign misaligned_s   = is_load_s & is_misaligned(uopIn.memOp.sz, uopIn.addrLo);
  assign unused_flags_s = ^uopIn.flags;

  // During a miss the extractor works on the captured load, otherwise on the live uop.
  assign align_addr_s = (state_q == ST_MISS_WAIT) ? ctx_q.addrLo     : uopIn.addrLo;
  assign align_sz_s   = (state_q == ST_MISS_WAIT) ? ctx_q.sz         : uopIn.memOp.sz;
  assign align_se_s   = (state_q == ST_MISS_WAIT) ? ctx_q.signExtend : uopIn.memOp.signExtend;

  load_align u_load_align (
    .data       (cacheRespData),
    .addrLo     (align_addr_s),
    .sz         (align_sz_s),
    .signExtend (align_se_s),
    .result     (load_word_s)
  );

`ifdef WB_MISS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MISS_TIMEOUT - 32'sd1);

  logic [7:0] timer_q, timer_d;

  assign timeout_s = (timer_q == TIMEOUT_LAST);

  // Miss timer next value: counts unanswered MISS_WAIT cycles
  always_comb begin
    if (state_q == ST_MISS_WAIT && !cacheRespValid) begin
      timer_d = timer_q + 8'd1;
    end else begin
      timer_d = 8'd0;
    end
  end

  // Miss timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, retirement and exception decode
  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    retire_s   = 1'b0;
    accepted_s = 1'b0;
    stall_s    = 1'b0;
    rf_we_s    = 1'b0;
    rf_addr_s  = 5'd0;
    rf_data_s  = 32'd0;
    ex_valid_s = 1'b0;
    ex_code_s  = EX_NONE;
    case (state_q)
      ST_IDLE: begin
        if (u.valid) begin
          accepted_s = 1'b1;
          rf_addr_s  = uopIn.rd;
          if (uopIn.ex != EX_NONE) begin
            ex_valid_s = 1'b1;
            ex_code_s  = uopIn.ex;
            state_d    = ST_TRAP;
          end else if (misaligned_s) begin
            ex_valid_s = 1'b1;
            ex_code_s  = EX_MEM_ALIGN;
            state_d    = ST_TRAP;
          end else if (is_load_s) begin
            if (cacheHit) begin
              rf_we_s   = (uopIn.rd != 5'd0);
              rf_data_s = load_word_s;
              retire_s  = 1'b1;
            end else begin
              ctx_d   = '{rd: uopIn.rd, sz: uopIn.memOp.sz,
                          signExtend: uopIn.memOp.signExtend, addrLo: uopIn.addrLo};
              state_d = ST_MISS_WAIT;
            end
          end else begin
            rf_we_s   = (uopIn.rd != 5'd0);
            rf_data_s = uopIn.rdVal;
            retire_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MISS_WAIT: begin
        stall_s   = 1'b1;
        rf_addr_s = ctx_q.rd;
        if (cacheRespValid) begin
          rf_we_s   = (ctx_q.rd != 5'd0);
          rf_data_s = load_word_s;
          retire_s  = 1'b1;
          state_d   = ST_IDLE;
        end else if (timeout_s) begin
          ex_valid_s = 1'b1;
          ex_code_s  = EX_MEM_MISS;
          state_d    = ST_TRAP;
        end else begin
          state_d = ST_MISS_WAIT;
        end
      end
      ST_TRAP: begin
        stall_s = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (retire_s) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // State, captured miss context and retirement counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctx_q     <= MISS_CTX_RESET;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      instret_q <= instret_d;
    end
  end

  assign u.stall           = stall_s;
  assign rfWe              = rf_we_s;
  assign rfAddr            = rf_addr_s;
  assign rfData            = rf_data_s;
  assign exValid           = ex_valid_s;
  assign exCode            = ex_code_s;
  assign instret           = instret_q;
  assign bypass.rValid     = rf_we_s;
  assign bypass.r          = rf_addr_s;
  assign bypass.rVal       = rf_data_s;
  assign bypass.flagsValid = accepted_s & uopIn.flagsValid;

endmodule
